// File: rtl/minesweeper_pkg.sv
// Grid geometry, cell display codes and board FSM encoding shared by the cursor and board stages.
package minesweeper_pkg;

    localparam int GRID_W    = 16;
    localparam int GRID_H    = 16;
    localparam int NUM_CELLS = GRID_W * GRID_H;

    localparam logic [3:0] CELL_HIDDEN = 4'd9;
    localparam logic [3:0] CELL_FLAG   = 4'd10;
    localparam logic [3:0] CELL_MINE   = 4'd11;
    localparam logic [3:0] CELL_BOOM   = 4'd12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PLACE,
        ST_PLAY,
        ST_CHECK,
        ST_COUNT,
        ST_WRITE,
        ST_LOST,
        ST_WON
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] idx;
    } nbr_t;

    // Per-axis step code: 0 = minus one, 1 = stay, 2 = plus one.
    function automatic logic [3:0] step_coord(input logic [3:0] c, input logic [1:0] d);
        logic [3:0] r;
        r = c;
        if (d == 2'd0) r = c - 4'd1;
        if (d == 2'd2) r = c + 4'd1;
        return r;
    endfunction

    function automatic logic coord_ok(input logic [3:0] c, input logic [1:0] d);
        return !((d == 2'd0 && c == 4'd0) || (d == 2'd2 && c == 4'd15));
    endfunction

    // Neighbour k in NW,N,NE,W,E,SW,S,SE order; vld=0 when it falls off the board.
    function automatic nbr_t neighbour(input logic [7:0] idx, input logic [2:0] k);
        logic [1:0] dx;
        logic [1:0] dy;
        nbr_t       n;
        dx = 2'd1;
        dy = 2'd1;
        case (k)
            3'd0: begin dx = 2'd0; dy = 2'd0; end
            3'd1: begin dx = 2'd1; dy = 2'd0; end
            3'd2: begin dx = 2'd2; dy = 2'd0; end
            3'd3: begin dx = 2'd0; dy = 2'd1; end
            3'd4: begin dx = 2'd2; dy = 2'd1; end
            3'd5: begin dx = 2'd0; dy = 2'd2; end
            3'd6: begin dx = 2'd1; dy = 2'd2; end
            default: begin dx = 2'd2; dy = 2'd2; end
        endcase
        n.vld = coord_ok(idx[3:0], dx) && coord_ok(idx[7:4], dy);
        n.idx = {step_coord(idx[7:4], dy), step_coord(idx[3:0], dx)};
        return n;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reloaded with SEED on reset.
// Advances every cycle, no stall input.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/board_state_ctrl.sv
// Minesweeper board owner: mine/flag/reveal maps, neighbour counts, game status; rd_code is 1-cycle.
// Reveal takes 11 cycles; place_flag/sel_sqr/sel_start pulses arriving while busy are dropped.
module board_state_ctrl
    import minesweeper_pkg::*;
#(
    parameter int          NUM_MINES = 40,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cursor_x,
    input  logic [3:0] cursor_y,
    input  logic       place_flag,
    input  logic       sel_sqr,
    input  logic       sel_start,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic [3:0] rd_code,
    output logic       busy,
    output logic       game_over,
    output logic       game_won
);

    localparam logic [8:0] SAFE_CELLS = 9'(NUM_CELLS - NUM_MINES);
    localparam logic [7:0] MINES_INIT = 8'(NUM_MINES);

    state_t                         state_q, state_d;
    logic [NUM_CELLS-1:0]           mine_q, mine_d;
    logic [NUM_CELLS-1:0]           flag_q, flag_d;
    logic [NUM_CELLS-1:0]           rev_q, rev_d;
    logic [NUM_CELLS-1:0][3:0]      count_q, count_d;
    logic [8:0]                     reveal_cnt_q, reveal_cnt_d;
    logic [7:0]                     idx_q, idx_d;
    logic [7:0]                     step_q, step_d;
    logic [3:0]                     sum_q, sum_d;
    logic [7:0]                     mines_left_q, mines_left_d;
    logic [7:0]                     exploded_q, exploded_d;
    logic                           game_over_q, game_over_d;
    logic                           game_won_q, game_won_d;
    logic                           busy_q, busy_d;
    logic [3:0]                     rd_code_q, rd_code_d;

    logic [15:0] lfsr_q;
    logic [7:0]  unused_lfsr_hi;
    logic [7:0]  cur_idx;
    logic [7:0]  rd_idx;
    logic [7:0]  place_idx;
    nbr_t        nbr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign unused_lfsr_hi = lfsr_q[15:8];
    assign cur_idx        = {cursor_y, cursor_x};
    assign rd_idx         = {rd_y, rd_x};
    assign place_idx      = lfsr_q[7:0];
    assign nbr            = neighbour(idx_q, step_q[2:0]);

    always_comb begin
        state_d      = state_q;
        mine_d       = mine_q;
        flag_d       = flag_q;
        rev_d        = rev_q;
        count_d      = count_q;
        reveal_cnt_d = reveal_cnt_q;
        idx_d        = idx_q;
        step_d       = step_q;
        sum_d        = sum_q;
        mines_left_d = mines_left_q;
        exploded_d   = exploded_q;
        game_over_d  = game_over_q;
        game_won_d   = game_won_q;

        case (state_q)
            ST_IDLE, ST_LOST, ST_WON: begin
                if (sel_start) begin
                    state_d      = ST_CLEAR;
                    step_d       = 8'd0;
                    reveal_cnt_d = 9'd0;
                    mines_left_d = MINES_INIT;
                    game_over_d  = 1'b0;
                    game_won_d   = 1'b0;
                end
            end
            ST_CLEAR: begin
                mine_d[step_q]  = 1'b0;
                flag_d[step_q]  = 1'b0;
                rev_d[step_q]   = 1'b0;
                count_d[step_q] = 4'd0;
                step_d          = step_q + 8'd1;
                if (step_q == 8'd255) begin
                    state_d = (mines_left_q == 8'd0) ? ST_PLAY : ST_PLACE;
                end
            end
            ST_PLACE: begin
                // Occupied draws are simply retried on the next LFSR value.
                if (!mine_q[place_idx]) begin
                    mine_d[place_idx] = 1'b1;
                    mines_left_d      = mines_left_q - 8'd1;
                    if (mines_left_q == 8'd1) state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (sel_sqr) begin
                    if (!flag_q[cur_idx] && !rev_q[cur_idx]) begin
                        idx_d   = cur_idx;
                        state_d = ST_CHECK;
                    end
                end else if (place_flag && !rev_q[cur_idx]) begin
                    flag_d[cur_idx] = !flag_q[cur_idx];
                end
            end
            ST_CHECK: begin
                if (mine_q[idx_q]) begin
                    exploded_d  = idx_q;
                    game_over_d = 1'b1;
                    state_d     = ST_LOST;
                end else begin
                    step_d  = 8'd0;
                    sum_d   = 4'd0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (nbr.vld) sum_d = sum_q + {3'b000, mine_q[nbr.idx]};
                step_d = step_q + 8'd1;
                if (step_q[2:0] == 3'd7) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                rev_d[idx_q]   = 1'b1;
                count_d[idx_q] = sum_q;
                reveal_cnt_d   = reveal_cnt_q + 9'd1;
                if (reveal_cnt_d == SAFE_CELLS) begin
                    game_won_d = 1'b1;
                    state_d    = ST_WON;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CLEAR) || (state_d == ST_PLACE) || (state_d == ST_CHECK) ||
                 (state_d == ST_COUNT) || (state_d == ST_WRITE);

        // Mines are only exposed after a loss; the exploded cell outranks everything.
        if (state_q == ST_LOST && rd_idx == exploded_q) begin
            rd_code_d = CELL_BOOM;
        end else if (rev_q[rd_idx]) begin
            rd_code_d = count_q[rd_idx];
        end else if (state_q == ST_LOST && mine_q[rd_idx]) begin
            rd_code_d = CELL_MINE;
        end else if (flag_q[rd_idx]) begin
            rd_code_d = CELL_FLAG;
        end else begin
            rd_code_d = CELL_HIDDEN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mine_q       <= '0;
            flag_q       <= '0;
            rev_q        <= '0;
            count_q      <= '0;
            reveal_cnt_q <= 9'd0;
            idx_q        <= 8'd0;
            step_q       <= 8'd0;
            sum_q        <= 4'd0;
            mines_left_q <= 8'd0;
            exploded_q   <= 8'd0;
            game_over_q  <= 1'b0;
            game_won_q   <= 1'b0;
            busy_q       <= 1'b0;
            rd_code_q    <= CELL_HIDDEN;
        end else begin
            state_q      <= state_d;
            mine_q       <= mine_d;
            flag_q       <= flag_d;
            rev_q        <= rev_d;
            count_q      <= count_d;
            reveal_cnt_q <= reveal_cnt_d;
            idx_q        <= idx_d;
            step_q       <= step_d;
            sum_q        <= sum_d;
            mines_left_q <= mines_left_d;
            exploded_q   <= exploded_d;
            game_over_q  <= game_over_d;
            game_won_q   <= game_won_d;
            busy_q       <= busy_d;
            rd_code_q    <= rd_code_d;
        end
    end

    assign rd_code   = rd_code_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;
    assign game_won  = game_won_q;

endmodule
